// File: rtl/router_pkg.sv
// Shared types and sizing helpers for the lane pop scheduler.
package router_pkg;

  localparam int unsigned NumLanes = 2;

  typedef logic [$clog2(NumLanes)-1:0] lane_t;

  // Enumerators are prefixed so they cannot collide with the BURST parameter.
  typedef enum logic [0:0] {
    StIdle,
    StBurst
  } sched_state_t;

  function automatic int unsigned credit_w(input int unsigned credits);
    return $clog2(credits + 1);
  endfunction

  function automatic int unsigned lane_w(input int unsigned lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

endpackage

// File: rtl/lane_pop_scheduler_if.sv
// FIFO-side handshake between the scheduler (master) and the multilane FIFO / link (slave).
interface lane_pop_scheduler_if
  import router_pkg::*;
#(
  parameter int unsigned LANES = 2
);

  localparam int unsigned LaneW = lane_w(LANES);

  logic [LANES-1:0] empty;
  logic [LANES-1:0] credit_return;
  logic             pop;
  logic [LaneW-1:0] pop_lane;

  modport master (
    input  empty,
    input  credit_return,
    output pop,
    output pop_lane
  );

  modport slave (
    output empty,
    output credit_return,
    input  pop,
    input  pop_lane
  );

endinterface

// File: rtl/lane_pop_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after i_ptr, wrapping mod LANES.
module rr_arbiter
  import router_pkg::*;
#(
  parameter int unsigned  LANES = 2,
  localparam int unsigned LaneW = lane_w(LANES)
) (
  input  logic [LANES-1:0] i_req,
  input  logic [LaneW-1:0] i_ptr,
  output logic [LANES-1:0] o_gnt,
  output logic [LaneW-1:0] o_gnt_idx,
  output logic             o_any
);

  localparam int unsigned SumW = LaneW + 1;

  logic [SumW-1:0] w_sum;

  always_comb begin
    o_gnt     = '0;
    o_gnt_idx = '0;
    o_any     = 1'b0;
    w_sum     = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      w_sum = {1'b0, i_ptr} + SumW'(i);
      if (w_sum >= SumW'(LANES)) begin
        w_sum = w_sum - SumW'(LANES);
      end
      if (!o_any && i_req[w_sum[LaneW-1:0]]) begin
        o_any                    = 1'b1;
        o_gnt[w_sum[LaneW-1:0]]  = 1'b1;
        o_gnt_idx                = w_sum[LaneW-1:0];
      end
    end
  end

endmodule

// File: rtl/lane_pop_scheduler.sv
// Drains a multilane FIFO onto one link: credit-gated round-robin with a bounded burst lock.
module lane_pop_scheduler
  import router_pkg::*;
#(
  parameter int unsigned  LANES   = 2,
  parameter int unsigned  CREDITS = 4,
  parameter int unsigned  BURST   = 2,
  localparam int unsigned LaneW   = lane_w(LANES)
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_enable,
  lane_pop_scheduler_if.master  bus,
  output logic                  o_locked,
  output logic                  o_credit_overflow
);

  localparam int unsigned CredW = credit_w(CREDITS);
  localparam int unsigned CntW  = credit_w(BURST);

  sched_state_t     r_state, w_state_nxt;
  logic [LaneW-1:0] r_cur_lane, w_cur_lane_nxt;
  logic [LaneW-1:0] r_rr_ptr, w_rr_ptr_nxt;
  logic [CntW-1:0]  r_burst_cnt, w_burst_cnt_nxt;
  logic [CredW-1:0] r_credit [LANES];
  logic             r_overflow;

  logic [LANES-1:0] w_eligible;
  logic [LANES-1:0] w_gnt;
  logic [LANES-1:0] w_pop_oh;
  logic [LaneW-1:0] w_gnt_idx;
  logic [LaneW-1:0] w_rel_ptr;
  logic [LaneW-1:0] w_arb_ptr;
  logic [LaneW-1:0] w_pop_lane;
  logic             w_any;
  logic             w_pop;

  function automatic logic [LaneW-1:0] inc_lane(input logic [LaneW-1:0] l);
    if (32'(l) == LANES - 1) begin
      return '0;
    end
    return l + 1'b1;
  endfunction

  always_comb begin
    for (int unsigned l = 0; l < LANES; l++) begin
      w_eligible[l] = ~bus.empty[l] & (r_credit[l] != '0);
    end
  end

  // A release in BURST re-arbitrates in the same cycle starting after the released lane.
  assign w_rel_ptr = inc_lane(r_cur_lane);
  assign w_arb_ptr = (r_state == StBurst) ? w_rel_ptr : r_rr_ptr;

  rr_arbiter #(
    .LANES (LANES)
  ) u_rr_arbiter (
    .i_req     (w_eligible),
    .i_ptr     (w_arb_ptr),
    .o_gnt     (w_gnt),
    .o_gnt_idx (w_gnt_idx),
    .o_any     (w_any)
  );

  always_comb begin
    w_state_nxt     = r_state;
    w_cur_lane_nxt  = r_cur_lane;
    w_rr_ptr_nxt    = r_rr_ptr;
    w_burst_cnt_nxt = r_burst_cnt;
    w_pop           = 1'b0;
    w_pop_lane      = '0;
    w_pop_oh        = '0;
    if (i_enable) begin
      if (r_state == StBurst && w_eligible[r_cur_lane]) begin
        w_pop                = 1'b1;
        w_pop_lane           = r_cur_lane;
        w_pop_oh[r_cur_lane] = 1'b1;
        if (32'(r_burst_cnt) + 1 >= BURST) begin
          w_state_nxt     = StIdle;
          w_burst_cnt_nxt = '0;
          w_rr_ptr_nxt    = w_rel_ptr;
        end else begin
          w_burst_cnt_nxt = r_burst_cnt + 1'b1;
        end
      end else begin
        if (r_state == StBurst) begin
          w_state_nxt     = StIdle;
          w_burst_cnt_nxt = '0;
          w_rr_ptr_nxt    = w_rel_ptr;
        end
        if (w_any) begin
          w_pop      = 1'b1;
          w_pop_lane = w_gnt_idx;
          w_pop_oh   = w_gnt;
          if (BURST > 1) begin
            w_state_nxt     = StBurst;
            w_cur_lane_nxt  = w_gnt_idx;
            w_burst_cnt_nxt = CntW'(1);
          end else begin
            w_rr_ptr_nxt = inc_lane(w_gnt_idx);
          end
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state     <= StIdle;
      r_cur_lane  <= '0;
      r_rr_ptr    <= '0;
      r_burst_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cur_lane  <= w_cur_lane_nxt;
      r_rr_ptr    <= w_rr_ptr_nxt;
      r_burst_cnt <= w_burst_cnt_nxt;
    end
  end

  // Pop and return on the same lane cancel; a return at full credit is flagged, not counted.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int unsigned l = 0; l < LANES; l++) begin
        r_credit[l] <= CredW'(CREDITS);
      end
      r_overflow <= 1'b0;
    end else begin
      for (int unsigned l = 0; l < LANES; l++) begin
        if (w_pop_oh[l] && !bus.credit_return[l]) begin
          r_credit[l] <= r_credit[l] - 1'b1;
        end else if (!w_pop_oh[l] && bus.credit_return[l]) begin
          if (r_credit[l] == CredW'(CREDITS)) begin
            r_overflow <= 1'b1;
          end else begin
            r_credit[l] <= r_credit[l] + 1'b1;
          end
        end
      end
    end
  end

  assign bus.pop           = w_pop & i_reset;
  assign bus.pop_lane      = i_reset ? w_pop_lane : '0;
  assign o_locked          = (r_state == StBurst);
  assign o_credit_overflow = r_overflow;

endmodule
